// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: push-button front end for the game logic.
//   Synchronises, debounces and edge-detects the three DE1-SoC keys, arbitrates
//   left/right conflicts, and generates a level-dependent gravity tick that never
//   shares a cycle with a move strobe.
// Ports:
//   CLOCK_50      in   system clock
//   resetn        in   asynchronous active-low reset
//   key_left_n    in   raw left button, active-low, asynchronous
//   key_right_n   in   raw right button, active-low, asynchronous
//   key_rot_n     in   raw rotate button, active-low, asynchronous
//   gravity_en    in   1 = gravity counter runs, 0 = counter and pending tick hold
//   level         in   speed level 0..15
//   left_final    out  one-cycle move-left strobe
//   right_final   out  one-cycle move-right strobe
//   rot_final     out  one-cycle rotate strobe
//   tick_gravity  out  one-cycle gravity strobe
// Optional feature: define INPUT_AUTOREPEAT_EN for horizontal delayed auto-shift.
module tetris_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned GRAV_BASE       = 25000000,
  parameter int unsigned GRAV_STEP       = 2000000,
  parameter int unsigned GRAV_MIN        = 2500000,
  parameter int unsigned DAS_DELAY       = 8333333,
  parameter int unsigned DAS_RATE        = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       key_left_n,
  input  logic       key_right_n,
  input  logic       key_rot_n,
  input  logic       gravity_en,
  input  logic [3:0] level,
  output logic       left_final,
  output logic       right_final,
  output logic       rot_final,
  output logic       tick_gravity
);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  // bit 0 = left, bit 1 = right, bit 2 = rotate; all active-high after inversion
  logic [2:0] raw, sync1, sync2, stable, stable_q, press;
  assign raw = ~{key_rot_n, key_right_n, key_left_n};
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      sync1    <= '0;
      sync2    <= '0;
      stable_q <= '0;
      press    <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      press    <= stable & ~stable_q;
    end
  // a change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
  for (genvar k = 0; k < 3; k++) begin : g_db
    logic [DW-1:0] cnt;
    logic          st;
    always_ff @(posedge CLOCK_50 or negedge resetn)
      if (!resetn) begin
        cnt <= '0;
        st  <= 1'b0;
      end else if (sync2[k] == st) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        st  <= ~st;
      end else begin
        cnt <= cnt + DW'(1);
      end
    assign stable[k] = st;
  end
  // horizontal move requests before the left/right conflict filter
  logic [1:0] lr;
`ifdef INPUT_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} das_t;
  das_t        das_st [2];
  das_t        das_nx [2];
  logic [31:0] das_cnt [2];
  logic [31:0] das_cnt_nx [2];
  logic [1:0]  idle, acc;
  assign idle = {das_st[1] == IDLE, das_st[0] == IDLE};
  // a press is taken only while the other direction is idle and not being pressed too
  assign acc[0] = press[0] & idle[1] & ~(press[1] & idle[0]);
  assign acc[1] = press[1] & idle[0] & ~(press[0] & idle[1]);
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      das_st[0]  <= IDLE;
      das_st[1]  <= IDLE;
      das_cnt[0] <= '0;
      das_cnt[1] <= '0;
    end else begin
      das_st[0]  <= das_nx[0];
      das_st[1]  <= das_nx[1];
      das_cnt[0] <= das_cnt_nx[0];
      das_cnt[1] <= das_cnt_nx[1];
    end
  always_comb
    for (int i = 0; i < 2; i++) begin
      das_nx[i]     = das_st[i];
      das_cnt_nx[i] = das_cnt[i] + 32'd1;
      lr[i]         = 1'b0;
      if (!stable[i]) begin
        das_nx[i]     = IDLE;
        das_cnt_nx[i] = '0;
      end else if (das_st[i] == IDLE) begin
        lr[i]         = acc[i];
        das_nx[i]     = acc[i] ? DELAY : IDLE;
        das_cnt_nx[i] = '0;
      end else if (das_st[i] == DELAY && das_cnt[i] == DAS_DELAY - 1) begin
        lr[i]         = 1'b1;
        das_nx[i]     = REPEAT;
        das_cnt_nx[i] = '0;
      end else if (das_st[i] == REPEAT && das_cnt[i] == DAS_RATE - 1) begin
        lr[i]         = 1'b1;
        das_cnt_nx[i] = '0;
      end
    end
`else
  assign lr = press[1:0];
`endif
  logic [31:0] step_total, period, grav_cnt;
  logic        grav_req, pending, move, left_nx, right_nx;
  assign step_total = 32'(level) * GRAV_STEP;
  // subtract only when it cannot wrap, then clamp to the floor
  assign period   = (step_total >= GRAV_BASE || GRAV_BASE - step_total < GRAV_MIN) ?
                    GRAV_MIN : GRAV_BASE - step_total;
  assign grav_req = gravity_en & (grav_cnt >= period - 32'd1);
  assign left_nx  = lr[0] & ~lr[1];
  assign right_nx = lr[1] & ~lr[0];
  assign move     = left_nx | right_nx | press[2];
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      grav_cnt     <= '0;
      pending      <= 1'b0;
      left_final   <= 1'b0;
      right_final  <= 1'b0;
      rot_final    <= 1'b0;
      tick_gravity <= 1'b0;
    end else begin
      left_final   <= left_nx;
      right_final  <= right_nx;
      rot_final    <= press[2];
      // a tick blocked by a move strobe waits in pending; repeated requests merge
      tick_gravity <= gravity_en & (grav_req | pending) & ~move;
      if (gravity_en) begin
        grav_cnt <= grav_req ? '0 : grav_cnt + 32'd1;
        pending  <= (grav_req | pending) & move;
      end
    end
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb_tetris_input_ctrl: directed and randomized checks of tetris_input_ctrl against a behavioural model.
module tb_tetris_input_ctrl;
  localparam int D = 4, GB = 20, GS = 2, GM = 4, DD = 10, DR = 3;
  logic       clk = 1'b0, resetn = 1'b0, gen = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic [3:0] level = 4'd0;
  logic       left_final, right_final, rot_final, tick_gravity;
  int         total = 0, bad = 0;
  int         n, gcnt;
  logic [D+1:0] hist [3];
  bit [2:0]   stab, ev1, ev2;
  bit [1:0]   act;
  int         start [2];
  bit         pend;
  bit [3:0]   exp_o;
  int         cnt, lc, rc, oc, elapsed, ticks, seen;
  int         rt [$];
  int         hold [3];
`ifdef INPUT_AUTOREPEAT_EN
  int         want6 [$] = '{7, 17, 20, 23, 26, 29, 32, 35};
`else
  int         want6 [$] = '{7};
`endif
  always #5 clk = ~clk;
  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(D), .GRAV_BASE(GB), .GRAV_STEP(GS), .GRAV_MIN(GM),
    .DAS_DELAY(DD), .DAS_RATE(DR)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn),
    .key_left_n(key_n[0]), .key_right_n(key_n[1]), .key_rot_n(key_n[2]),
    .gravity_en(gen), .level(level),
    .left_final(left_final), .right_final(right_final),
    .rot_final(rot_final), .tick_gravity(tick_gravity)
  );
  function automatic void model_reset();
    n = 0; gcnt = 0; pend = 0; stab = '0; ev1 = '0; ev2 = '0; act = '0; exp_o = '0;
    start[0] = 0; start[1] = 0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
  endfunction
  // one clock edge of the reference: outputs registered now, then debounce bookkeeping
  function automatic void model_edge();
    bit [2:0] raw = ~key_n;
    bit [2:0] pr = ev2, held = stab, newp = '0;
    bit l, r, mv, req;
    int p = GB - int'(level) * GS;
`ifdef INPUT_AUTOREPEAT_EN
    bit [1:0] acc, rep;
    for (int i = 0; i < 2; i++) begin
      int age = n - start[i];
      rep[i] = act[i] && held[i] && (age == DD || (age > DD && (age - DD) % DR == 0));
    end
    acc[0] = pr[0] && !act[1] && !(pr[1] && !act[0]);
    acc[1] = pr[1] && !act[0] && !(pr[0] && !act[1]);
    for (int i = 0; i < 2; i++) begin
      if (!held[i]) act[i] = 0;
      else if (acc[i]) begin act[i] = 1; start[i] = n; end
    end
    l = acc[0] || rep[0];
    r = acc[1] || rep[1];
`else
    l = pr[0];
    r = pr[1];
`endif
    exp_o[3] = l && !r;
    exp_o[2] = r && !l;
    exp_o[1] = pr[2];
    mv = |exp_o[3:1];
    if (p < GM) p = GM;
    req = gen && gcnt >= p - 1;
    exp_o[0] = gen && (req || pend) && !mv;
    if (gen) begin
      gcnt = req ? 0 : gcnt + 1;
      pend = (req || pend) && mv;
    end
    for (int k = 0; k < 3; k++) begin
      hist[k] = {hist[k][D:0], raw[k]};
      if (hist[k][D+1:2] == {D{~stab[k]}}) begin
        stab[k] = ~stab[k];
        newp[k] = stab[k];
      end
    end
    ev2 = ev1;
    ev1 = newp;
    n++;
  endfunction
  task automatic cyc();
    @(posedge clk);
    if (resetn) model_edge();
    #1;
    total++;
    assert ({left_final, right_final, rot_final, tick_gravity} === exp_o) else begin
      bad++;
      $error("FAIL model n=%0d got=%b exp=%b", n, {left_final, right_final, rot_final, tick_gravity}, exp_o);
    end
  endtask
  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask
  task automatic press_latency(input string tag);
    int at = -1, c = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (left_final) begin
        c++;
        if (at < 0) at = i;
      end
    end
    chk({tag, "_at"}, at, D + 3);
    chk({tag, "_count"}, c, 1);
  endtask
  task automatic period_check(input string tag, input int want);
    int last = -1, got = 0;
    for (int i = 0; i < 100 && got < 2; i++) begin
      cyc();
      if (tick_gravity) begin
        if (last >= 0) begin
          chk(tag, i - last, want);
          got++;
        end
        last = i;
      end
    end
    chk({tag, "_seen"}, got, 2);
  endtask
  initial begin
    do_reset();
    chk("reset_out", int'({left_final, right_final, rot_final, tick_gravity}), 0);
    // short glitch is rejected, a held press strobes once after D+3 clocks
    key_n[0] = 1'b0;
    cyc(); cyc();
    key_n[0] = 1'b1;
    cnt = 0;
    repeat (12) begin cyc(); cnt += int'(left_final); end
    chk("glitch", cnt, 0);
    key_n[0] = 1'b0;
    press_latency("press");
    key_n[0] = 1'b1;
    repeat (12) cyc();
    // gravity period per level with floor
    gen = 1'b1;
    period_check("period_l0", 20);
    level = 4'd9;
    period_check("period_l9", 4);
    level = 4'd15;
    period_check("period_l15", 4);
    gen = 1'b0;
    // simultaneous left/right cancel, rotate still passes
    key_n = 3'b000;
    lc = 0; rc = 0; oc = 0;
    repeat (14) begin
      cyc();
      lc += int'(left_final); rc += int'(right_final); oc += int'(rot_final);
    end
    chk("lr_left", lc, 0);
    chk("lr_right", rc, 0);
    chk("lr_rot", oc, 1);
    key_n = 3'b111;
    repeat (12) cyc();
    // gravity request lands on the rotate strobe and slips one cycle
    do_reset();
    gen = 1'b1;
    level = 4'd15;
    key_n[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 7) begin
        chk("rot_at7", int'(rot_final), 1);
        chk("tick_at7", int'(tick_gravity), 0);
      end
      if (i == 8) chk("tick_at8", int'(tick_gravity), 1);
    end
    key_n[2] = 1'b1;
    // pause holds the count
    level = 4'd0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin cyc(); seen = int'(tick_gravity); end
    chk("tick_before_pause", seen, 1);
    elapsed = 0; ticks = 0;
    repeat (5) begin cyc(); elapsed++; ticks += int'(tick_gravity); end
    gen = 1'b0;
    repeat (50) begin cyc(); elapsed++; ticks += int'(tick_gravity); end
    chk("paused_ticks", ticks, 0);
    gen = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin cyc(); elapsed++; seen = int'(tick_gravity); end
    chk("resume_gap", elapsed, 70);
    // async reset mid-debounce while a tick is visible
    level = 4'd15;
    key_n[0] = 1'b0;
    repeat (D + 1) cyc();
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin cyc(); seen = int'(tick_gravity); end
    chk("tick_before_reset", seen, 1);
    resetn = 1'b0;
    #1;
    chk("async_reset", int'({left_final, right_final, rot_final, tick_gravity}), 0);
    do_reset();
    press_latency("post_reset");
    key_n[0] = 1'b1;
    gen = 1'b0;
    repeat (12) cyc();
    // held right: auto-repeat timing or a single strobe
    key_n[1] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 32) key_n[1] = 1'b1;
      cyc();
      if (right_final) rt.push_back(i);
    end
    chk("das_count", rt.size(), want6.size());
    for (int i = 0; i < rt.size() && i < want6.size(); i++) chk("das_time", rt[i], want6[i]);
    // randomized keys, gravity enable and level
    gen = 1'b1;
    for (int k = 0; k < 3; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          hold[k] = $urandom_range(1, 24);
          key_n[k] = 1'($urandom_range(0, 1));
        end else begin
          hold[k]--;
        end
      end
      if ($urandom_range(0, 49) == 0) gen = ~gen;
      if ($urandom_range(0, 199) == 0) level = 4'($urandom_range(0, 15));
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
